// File: rtl/freq_decimator_pkg.sv
// ---------------------------------------------------------------------------
// freq_decimator_pkg
// Shared constants and helpers for the frequency decimator and related
// decimating cores.
//   LOG2_NMAX_DEFAULT : default largest block exponent
//   log2n_width()     : bit width of a block-exponent port for a given max
//   clamp_log2n()     : saturate a requested exponent to the supported max
// ---------------------------------------------------------------------------
package freq_decimator_pkg;

   localparam int LOG2_NMAX_DEFAULT = 16;

   function automatic int log2n_width(input int nmax);
      return $clog2(nmax + 1);
   endfunction

   function automatic int clamp_log2n(input int v, input int nmax);
      return (v > nmax) ? nmax : v;
   endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// ---------------------------------------------------------------------------
// axis_hold_reg
// Single-entry AXI4-Stream-style output register. A load is accepted when
// the register is empty or is being drained on the same edge; otherwise the
// offered word is discarded and o_drop pulses so the owner can flag it.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_load      : offer i_data this cycle
//   i_data      : word to hold
//   i_tready    : downstream accepts the held word
//   o_tdata     : held word (stable while o_tvalid && !i_tready)
//   o_tvalid    : register holds an unconsumed word
//   o_drop      : offered word was discarded this cycle
// ---------------------------------------------------------------------------
module axis_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_tready,
   output logic [DATA_W-1:0] o_tdata,
   output logic              o_tvalid,
   output logic              o_drop
);

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              w_accept;

   // Empty, or the held word leaves on this edge: a new word may replace it.
   assign w_accept = !r_valid || i_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load && w_accept) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (r_valid && i_tready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_tdata  = r_data;
   assign o_tvalid = r_valid;
   assign o_drop   = i_load && !w_accept;

endmodule

// File: rtl/freq_decimator.sv
// ---------------------------------------------------------------------------
// freq_decimator
// Sums blocks of 2^n valid frequency samples and emits the full-precision
// sum plus its arithmetic mean (floor) through a single-entry output register
// with backpressure and a sticky overrun flag.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   din, din_valid  : signed frequency sample and its qualifier
//   log2_n          : block exponent, clamped to LOG2_NMAX, latched per block
//   m_axis_tdata    : signed block sum
//   m_axis_tmean    : signed block mean (sum >>> n)
//   m_axis_tvalid   : result held and not yet consumed
//   m_axis_tready   : downstream accepts the result
//   clear_overrun   : synchronous clear of overrun (a same-edge drop wins)
//   overrun         : sticky, a block result was dropped
// ---------------------------------------------------------------------------
module freq_decimator
   import freq_decimator_pkg::*;
#(
   parameter int DIN_WIDTH  = 17,
   parameter int LOG2_NMAX  = LOG2_NMAX_DEFAULT,
   parameter int DOUT_WIDTH = DIN_WIDTH + LOG2_NMAX
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic signed [DIN_WIDTH-1:0]           din,
   input  logic                                  din_valid,
   input  logic [log2n_width(LOG2_NMAX)-1:0]     log2_n,
   output logic signed [DOUT_WIDTH-1:0]          m_axis_tdata,
   output logic signed [DIN_WIDTH-1:0]           m_axis_tmean,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   input  logic                                  clear_overrun,
   output logic                                  overrun
);

   localparam int NW = log2n_width(LOG2_NMAX);

   logic signed [DOUT_WIDTH-1:0] r_acc;
   logic [LOG2_NMAX-1:0]         r_cnt;
   logic [NW-1:0]                r_n;
   logic                         r_overrun;

   logic [NW-1:0]                w_n_clamped;
   logic [NW-1:0]                w_n_eff;
   logic                         w_first;
   logic                         w_end;
   logic signed [DOUT_WIDTH-1:0] w_din_ext;
   logic signed [DOUT_WIDTH-1:0] w_sum;
   logic signed [DIN_WIDTH-1:0]  w_mean;
   logic                         w_load;
   logic                         w_drop;
   logic [DIN_WIDTH+DOUT_WIDTH-1:0] w_hold_data;

   assign w_n_clamped = NW'(clamp_log2n(int'(log2_n), LOG2_NMAX));

   // The first sample of a block uses the live (clamped) exponent so that a
   // one-sample block (n = 0) completes on that same edge; later samples use
   // the latched value.
   assign w_first = (r_cnt == '0);
   assign w_n_eff = w_first ? w_n_clamped : r_n;

   // Last sample when counter == 2^n - 1; compare one bit wider so n = LOG2_NMAX works.
   assign w_end = ({1'b0, r_cnt} ==
                   (((LOG2_NMAX+1)'(1)) << w_n_eff) - (LOG2_NMAX+1)'(1));

   assign w_din_ext = {{LOG2_NMAX{din[DIN_WIDTH-1]}}, din};
   assign w_sum     = r_acc + w_din_ext;
   // Arithmetic shift floors toward -inf; the quotient always fits DIN_WIDTH.
   assign w_mean    = DIN_WIDTH'(w_sum >>> w_n_eff);

   assign w_load    = din_valid && w_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_n   <= '0;
      end else if (din_valid) begin
         if (w_first) begin
            r_n <= w_n_clamped;
         end
         if (w_end) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LOG2_NMAX'(1);
         end
      end
   end

   axis_hold_reg #(
      .DATA_W (DIN_WIDTH + DOUT_WIDTH)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_data   ({w_mean, w_sum}),
      .i_tready (m_axis_tready),
      .o_tdata  (w_hold_data),
      .o_tvalid (m_axis_tvalid),
      .o_drop   (w_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (clear_overrun) begin
         r_overrun <= 1'b0;
      end
   end

   assign m_axis_tdata = w_hold_data[DOUT_WIDTH-1:0];
   assign m_axis_tmean = w_hold_data[DIN_WIDTH+DOUT_WIDTH-1:DOUT_WIDTH];
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_freq_decimator.sv
// ---------------------------------------------------------------------------
// tb_freq_decimator
// Self-checking bench: a table of whole blocks plus hand-written sequences
// for backpressure/overrun, exponent changes, mid-block reset and the
// clamped maximum block length. Expected results are queued when the last
// sample of a block is driven and popped when the DUT transfers a result.
// ---------------------------------------------------------------------------
module tb_freq_decimator;

   localparam int DIN_W  = 17;
   localparam int NMAX   = 16;
   localparam int DOUT_W = DIN_W + NMAX;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic signed [DIN_W-1:0]  din = '0;
   logic                     din_valid = 1'b0;
   logic [4:0]               log2_n = '0;
   logic signed [DOUT_W-1:0] m_axis_tdata;
   logic signed [DIN_W-1:0]  m_axis_tmean;
   logic                     m_axis_tvalid;
   logic                     m_axis_tready = 1'b1;
   logic                     clear_overrun = 1'b0;
   logic                     overrun;

   freq_decimator #(
      .DIN_WIDTH  (DIN_W),
      .LOG2_NMAX  (NMAX),
      .DOUT_WIDTH (DOUT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .din           (din),
      .din_valid     (din_valid),
      .log2_n        (log2_n),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tmean  (m_axis_tmean),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .clear_overrun (clear_overrun),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic signed [DOUT_W-1:0] sum;
      logic signed [DIN_W-1:0]  mean;
   } exp_t;

   typedef struct packed {
      logic [4:0]        log2n;
      logic [3:0]        nsamp;
      logic              gap;
      logic [0:7][15:0]  samp;
      logic signed [DOUT_W-1:0] exp_sum;
      logic signed [DIN_W-1:0]  exp_mean;
   } blk_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Scoreboard consumer: sampled on the falling edge, the values seen here
   // are exactly those present at the next rising (transfer) edge.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got tdata %0d with empty scoreboard", m_axis_tdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_tdata", longint'(m_axis_tdata), longint'(e.sum));
            chk("sb_tmean", longint'(m_axis_tmean), longint'(e.mean));
         end
      end
   end

   task automatic push_exp(input longint s, input longint m);
      exp_t e;
      e.sum  = DOUT_W'(s);
      e.mean = DIN_W'(m);
      sb.push_back(e);
   endtask

   // Drive one cycle of input, returning 1 time unit after the rising edge.
   task automatic step(input bit v, input longint d);
      din       = DIN_W'(d);
      din_valid = v;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   // Wait (bounded) until every queued result has been transferred.
   task automatic drain(input string name);
      int k;
      k = 0;
      while ((sb.size() != 0 || m_axis_tvalid) && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({name, "_drained"}, longint'(sb.size()), 0);
      chk({name, "_tvalid_low"}, longint'(m_axis_tvalid), 0);
   endtask

   blk_t blks [5];

   initial begin
      blks[0] = '{log2n: 5'd2, nsamp: 4'd4, gap: 1'b0,
                  samp: {16'd1, 16'd3, 16'hFFFE, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0},
                  exp_sum: 33'sd8, exp_mean: 17'sd2};
      blks[1] = '{log2n: 5'd3, nsamp: 4'd8, gap: 1'b1,
                  samp: {8{16'hFFFB}},
                  exp_sum: -33'sd40, exp_mean: -17'sd5};
      blks[2] = '{log2n: 5'd1, nsamp: 4'd2, gap: 1'b0,
                  samp: {16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  exp_sum: -33'sd3, exp_mean: -17'sd2};
      blks[3] = '{log2n: 5'd0, nsamp: 4'd1, gap: 1'b0,
                  samp: {16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  exp_sum: 33'sd5, exp_mean: 17'sd5};
      blks[4] = '{log2n: 5'd2, nsamp: 4'd4, gap: 1'b1,
                  samp: {16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF8, 16'd0, 16'd0, 16'd0, 16'd0},
                  exp_sum: -33'sd29, exp_mean: -17'sd8};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tdata",   longint'(m_axis_tdata), 0);
      chk("rst_tmean",   longint'(m_axis_tmean), 0);
      chk("rst_tvalid",  longint'(m_axis_tvalid), 0);
      chk("rst_overrun", longint'(overrun), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---- table of whole blocks, tready held high ----
      for (int i = 0; i < 5; i++) begin
         log2_n = blks[i].log2n;
         for (int j = 0; j < int'(blks[i].nsamp); j++) begin
            if (j == int'(blks[i].nsamp) - 1)
               push_exp(longint'(blks[i].exp_sum), longint'(blks[i].exp_mean));
            step(1'b1, longint'($signed(blks[i].samp[j])));
            if (j == int'(blks[i].nsamp) - 1)
               chk($sformatf("blk%0d_latency_tvalid", i), longint'(m_axis_tvalid), 1);
            else if (blks[i].gap)
               step(1'b0, 99);
         end
         drain($sformatf("blk%0d", i));
         chk($sformatf("blk%0d_overrun", i), longint'(overrun), 0);
      end

      // ---- backpressure: second n=0 result dropped, overrun set ----
      m_axis_tready = 1'b0;
      log2_n = 5'd0;
      push_exp(7, 7);
      step(1'b1, 7);
      step(1'b1, 9);
      chk("ovr_tvalid",  longint'(m_axis_tvalid), 1);
      chk("ovr_tdata",   longint'(m_axis_tdata), 7);
      chk("ovr_overrun", longint'(overrun), 1);
      step(1'b0, 0);
      chk("ovr_tdata_stable", longint'(m_axis_tdata), 7);
      chk("ovr_tmean_stable", longint'(m_axis_tmean), 7);
      m_axis_tready = 1'b1;
      step(1'b0, 0);
      chk("ovr_transferred", longint'(m_axis_tvalid), 0);
      chk("ovr_still_sticky", longint'(overrun), 1);
      clear_overrun = 1'b1;
      step(1'b0, 0);
      clear_overrun = 1'b0;
      chk("ovr_cleared", longint'(overrun), 0);
      drain("ovr");

      // ---- drop and clear on the same edge: set wins ----
      m_axis_tready = 1'b0;
      push_exp(4, 4);
      step(1'b1, 4);
      clear_overrun = 1'b1;
      step(1'b1, 5);
      clear_overrun = 1'b0;
      chk("setwins_overrun", longint'(overrun), 1);
      m_axis_tready = 1'b1;
      clear_overrun = 1'b1;
      step(1'b0, 0);
      clear_overrun = 1'b0;
      chk("setwins_cleared", longint'(overrun), 0);
      drain("setwins");

      // ---- log2_n change mid-block only applies at the boundary ----
      log2_n = 5'd2;
      step(1'b1, 1);
      step(1'b1, 2);
      log2_n = 5'd1;
      step(1'b1, 3);
      push_exp(10, 2);
      step(1'b1, 4);
      step(1'b1, 5);
      push_exp(11, 5);
      step(1'b1, 6);
      drain("nchange");

      // ---- reset mid-block discards the partial sum ----
      log2_n = 5'd2;
      step(1'b1, 100);
      step(1'b1, 100);
      step(1'b1, 100);
      #2 rst = 1'b1;
      #2;
      chk("midrst_tvalid", longint'(m_axis_tvalid), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      push_exp(4, 1);
      repeat (3) step(1'b1, 1);
      chk("midrst_not_early", longint'(m_axis_tvalid), 0);
      step(1'b1, 1);
      drain("midrst");

      // ---- exponent above max clamps to 16: 65536 samples ----
      log2_n = 5'd31;
      for (int k = 0; k < 65536; k++) begin
         if (k == 65535) push_exp(64'd4294901760, 65535);
         step(1'b1, 65535);
         if (k == 65534)
            chk("clamp_not_early", longint'(m_axis_tvalid), 0);
      end
      chk("clamp_tvalid", longint'(m_axis_tvalid), 1);
      drain("clamp");
      chk("final_overrun", longint'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_decimator.md
Name: freq_decimator

Overview:
- Downstream stage of the phase unwrapper: consumes the signed per-sample frequency word (unwrapped phase difference).
- Sums blocks of 2^log2_n valid samples and emits one full-precision sum plus its arithmetic mean per block.
- Output is a single-entry AXI4-Stream-style register with backpressure and a sticky overrun flag, so the result can feed a FIFO or DMA at a reduced rate.

Parameters:
- DIN_WIDTH, 17, width of the signed input frequency word.
- LOG2_NMAX, 16, largest supported log2 of the block length.
- DOUT_WIDTH, DIN_WIDTH+LOG2_NMAX, width of the signed sum output; guarantees no overflow.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  DIN_WIDTH  signed frequency sample.
- din_valid  in  1  din is a valid sample this cycle.
- log2_n  in  $clog2(LOG2_NMAX+1)  block length exponent; values above LOG2_NMAX are clamped to LOG2_NMAX.
- m_axis_tdata  out  DOUT_WIDTH  signed block sum.
- m_axis_tmean  out  DIN_WIDTH  signed block mean, equal to sum >>> n (arithmetic shift).
- m_axis_tvalid  out  1  output register holds an unconsumed result.
- m_axis_tready  in  1  downstream accepts the result.
- clear_overrun  in  1  synchronous clear of overrun.
- overrun  out  1  sticky flag: at least one block result was dropped.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - Accumulator, sample counter, latched n, m_axis_tdata, m_axis_tmean, m_axis_tvalid and overrun all go to 0.
  - A reset mid-block discards the partial sum.
- Block start (counter == 0):
  - n is latched as min(log2_n, LOG2_NMAX) on the first valid sample of each block.
  - log2_n changes take effect only at block boundaries; a block in progress keeps its latched n.
- Accumulation:
  - On each din_valid cycle, din is sign-extended to DOUT_WIDTH and added.
  - The counter increments and wraps at 2^n - 1. Cycles with din_valid = 0 leave all state unchanged.
- Block end (valid sample with counter == 2^n - 1):
  - The candidate result is acc + din.
  - Accumulator and counter return to 0 on the same edge, so there is no dead cycle between blocks.
- Latency: m_axis_tvalid rises on the clock edge that samples the last block sample, so it is visible the following cycle. m_axis_tmean is registered in the same edge as m_axis_tdata.
- n = 0: every valid sample is its own block. tdata is the sign-extended din and tmean equals din, with 1-cycle latency.
- Handshake:
  - A transfer occurs on any edge with tvalid && tready. tvalid then drops unless a new result loads on the same edge.
  - tdata and tmean stay stable while tvalid && !tready.
- Output register load rules on a block-end edge:
  - Register empty, or tready = 1: the new result loads and tvalid = 1. Back-to-back results with tready held high never overrun.
  - tvalid = 1 and tready = 0: the new result is dropped, the held result is kept, and overrun is set to 1.
- clear_overrun:
  - Clears overrun to 0 on the next edge.
  - If a drop and clear_overrun occur on the same edge, the set wins and overrun = 1.
- Arithmetic:
  - All arithmetic is two's-complement signed; the mean truncates toward -infinity.
  - The sum cannot overflow for n <= LOG2_NMAX.
- No combinational path from any input to any output.

Decomposition:
- Shared package: constant LOG2_NMAX_DEFAULT = 16 and a function computing the clamp/width for log2_n.
- One natural sub-module, axis_hold_reg: a single-entry output register with tvalid/tready and a drop strobe, reusable by other decimating cores.
- The accumulator, counter and n latch stay in freq_decimator.

Test Plan:
- Reset release, log2_n = 2, din = 1, 3, -2, 6 all valid, tready = 1 -> one cycle after the 4th sample: tdata = 8, tmean = 2, tvalid for 1 cycle, overrun = 0.
- log2_n = 3, din = -5 for 8 valid samples with din_valid toggling 1,0 -> tdata = -40, tmean = -5; gap cycles do not count toward the block.
- log2_n = 1, din = -3, 0 -> tdata = -3, tmean = -2 (floor check).
- log2_n = 0, tready = 0, din = 7 then 9 -> tdata stays 7 with tvalid = 1 and overrun = 1; raise tready -> 7 transfers; clear_overrun -> overrun = 0.
- Drop and clear_overrun on the same edge -> overrun = 1 afterwards.
- Change log2_n from 2 to 1 after the 2nd sample of a block -> that block still sums 4 samples, and the next block sums 2.
- Assert rst mid-block after 3 of 4 samples, then feed 4 samples of value 1 -> tdata = 4 (partial sum discarded).
- log2_n = 31 (above LOG2_NMAX) -> clamped to n = 16; feed 65536 samples of 2^16-1 -> tdata = 4294901760, tmean = 65535.
